// File: rtl/core_comm.sv
// Shared ROB-age types and helpers for units that sit between writeback and commit.
package core_comm;

  localparam int ROB_DEPTH = 64;
  localparam int ROB_IW    = $clog2(ROB_DEPTH);
  localparam int ROB_RW    = 1 + ROB_IW;

  typedef struct packed {
    logic              flipped;
    logic [ROB_IW-1:0] idx;
  } robIdx_t;

  // flipped toggles on each index wrap, so unequal flipped bits reverse the idx order
  function automatic logic rob_is_older(robIdx_t a, robIdx_t b);
    return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

  typedef enum logic [15:0] {
    EXC_INST_MISALIGN  = 16'd0,
    EXC_INST_FAULT     = 16'd1,
    EXC_ILLEGAL_INST   = 16'd2,
    EXC_BREAKPOINT     = 16'd3,
    EXC_LOAD_MISALIGN  = 16'd4,
    EXC_LOAD_FAULT     = 16'd5,
    EXC_STORE_MISALIGN = 16'd6,
    EXC_STORE_FAULT    = 16'd7,
    EXC_ECALL_U        = 16'd8,
    EXC_ECALL_S        = 16'd9,
    EXC_ECALL_M        = 16'd11,
    EXC_INST_PAGE      = 16'd12,
    EXC_LOAD_PAGE      = 16'd13,
    EXC_STORE_PAGE     = 16'd15
  } rv_trap_t;

  typedef struct packed {
    robIdx_t      rob_idx;
    logic [15:0]  cause;
    logic [63:0]  tval;
  } exc_report_t;

  typedef enum logic [1:0] {
    EXC_IDLE = 2'd0,
    EXC_PEND = 2'd1,
    EXC_TRAP = 2'd2
  } exc_state_t;

endpackage

// File: rtl/rob_oldest_sel.sv
// Picks the oldest valid robIdx among N candidates with a binary tree of age compares.
// On equal age the lower-numbered candidate wins.
module rob_oldest_sel
  import core_comm::*;
#(
  parameter int N = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               [N-1:0] vld,
  input  robIdx_t            [N-1:0] idx,
  output logic                       found,
  output logic [SW-1:0]              sel
);

  localparam int LV = $clog2(N);
  localparam int P  = 1 << LV;

  logic            node_vld [2*P];
  robIdx_t         node_idx [2*P];
  logic [SW-1:0]   node_sel [2*P];

  // heap layout: node k has children 2k and 2k+1, leaves at P..2P-1
  always_comb begin
    for (int i = 0; i < 2*P; i++) begin
      node_vld[i] = 1'b0;
      node_idx[i] = '0;
      node_sel[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      node_vld[P+i] = vld[i];
      node_idx[P+i] = idx[i];
      node_sel[P+i] = SW'(i);
    end
    for (int k = P-1; k >= 1; k--) begin
      if (node_vld[2*k+1] &&
          (!node_vld[2*k] || rob_is_older(node_idx[2*k+1], node_idx[2*k]))) begin
        node_vld[k] = 1'b1;
        node_idx[k] = node_idx[2*k+1];
        node_sel[k] = node_sel[2*k+1];
      end else begin
        node_vld[k] = node_vld[2*k];
        node_idx[k] = node_idx[2*k];
        node_sel[k] = node_sel[2*k];
      end
    end
    found = node_vld[1];
    sel   = node_sel[1];
  end

endmodule

// File: rtl/exception_tracker.sv
// Holds the oldest unresolved exception and requests a trap once it reaches the ROB head.
//  state | meaning
//  IDLE  | nothing held, outputs zero
//  PEND  | exception held, waiting for it to become ROB head
//  TRAP  | held exception is at head, trap requested until ack
module exception_tracker
  import core_comm::*;
#(
  parameter int NUM_REPORT = 4,
  parameter int ROB_SIZE   = ROB_DEPTH,
  parameter int CAUSE_W    = 16,
  parameter int TVAL_W     = 64,
  parameter int CNT_W      = 16,
  localparam int RW = 1 + $clog2(ROB_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REPORT-1:0]           i_rep_vld,
  input  logic [NUM_REPORT*RW-1:0]        i_rep_robIdx,
  input  logic [NUM_REPORT*CAUSE_W-1:0]   i_rep_cause,
  input  logic [NUM_REPORT*TVAL_W-1:0]    i_rep_tval,
  input  logic [RW-1:0]                   i_head_robIdx,
  input  logic                            i_squash_vld,
  input  logic [RW-1:0]                   i_squash_robIdx,
  input  logic                            i_flush,
  input  logic                            i_trap_ack,
  output logic                            o_exc_vld,
  output logic [RW-1:0]                   o_exc_robIdx,
  output logic [CAUSE_W-1:0]              o_exc_cause,
  output logic [TVAL_W-1:0]               o_exc_tval,
  output logic                            o_trap_req,
  output logic [CNT_W-1:0]                o_trap_cnt
);

  localparam int SW = (NUM_REPORT > 1) ? $clog2(NUM_REPORT) : 1;

  exc_state_t               state;
  robIdx_t                  held_idx;
  logic [CAUSE_W-1:0]       held_cause;
  logic [TVAL_W-1:0]        held_tval;
  logic                     exc_vld_q;
  logic                     trap_req_q;
  logic [CNT_W-1:0]         cnt_q;

  robIdx_t                  head_idx;
  robIdx_t                  sq_idx;
  robIdx_t [NUM_REPORT-1:0] rep_idx;
  logic [NUM_REPORT-1:0]    rep_keep;

  logic                     sel_found;
  logic [SW-1:0]            sel_ch;
  robIdx_t                  sel_idx;
  logic [CAUSE_W-1:0]       sel_cause;
  logic [TVAL_W-1:0]        sel_tval;

  exc_state_t               nxt_state;
  robIdx_t                  nxt_idx;
  logic [CAUSE_W-1:0]       nxt_cause;
  logic [TVAL_W-1:0]        nxt_tval;
  logic                     cnt_inc;

  assign head_idx = robIdx_t'(i_head_robIdx);
  assign sq_idx   = robIdx_t'(i_squash_robIdx);

  // reports strictly younger than the squash point belong to squashed work
  always_comb begin
    for (int c = 0; c < NUM_REPORT; c++) begin
      rep_idx[c]  = robIdx_t'(i_rep_robIdx[c*RW +: RW]);
      rep_keep[c] = i_rep_vld[c] && !(i_squash_vld && rob_is_older(sq_idx, rep_idx[c]));
    end
  end

  rob_oldest_sel #(.N(NUM_REPORT)) u_sel (
    .vld   (rep_keep),
    .idx   (rep_idx),
    .found (sel_found),
    .sel   (sel_ch)
  );

  assign sel_idx   = rep_idx[sel_ch];
  assign sel_cause = i_rep_cause[sel_ch*CAUSE_W +: CAUSE_W];
  assign sel_tval  = i_rep_tval[sel_ch*TVAL_W +: TVAL_W];

  always_comb begin
    nxt_state = state;
    nxt_idx   = held_idx;
    nxt_cause = held_cause;
    nxt_tval  = held_tval;
    cnt_inc   = 1'b0;
    case (state)
      EXC_IDLE: begin
        if (sel_found) begin
          nxt_state = EXC_PEND;
          nxt_idx   = sel_idx;
          nxt_cause = sel_cause;
          nxt_tval  = sel_tval;
        end
      end
      EXC_PEND: begin
        if (i_squash_vld && rob_is_older(sq_idx, held_idx)) begin
          if (sel_found) begin
            nxt_idx   = sel_idx;
            nxt_cause = sel_cause;
            nxt_tval  = sel_tval;
          end else begin
            nxt_state = EXC_IDLE;
            nxt_idx   = '0;
            nxt_cause = '0;
            nxt_tval  = '0;
          end
        end else if (sel_found && rob_is_older(sel_idx, held_idx)) begin
          nxt_idx   = sel_idx;
          nxt_cause = sel_cause;
          nxt_tval  = sel_tval;
        end
      end
      EXC_TRAP: begin
        if (i_trap_ack) begin
          nxt_state = EXC_IDLE;
          nxt_idx   = '0;
          nxt_cause = '0;
          nxt_tval  = '0;
          cnt_inc   = 1'b1;
        end
      end
      default: begin
        nxt_state = EXC_IDLE;
        nxt_idx   = '0;
        nxt_cause = '0;
        nxt_tval  = '0;
      end
    endcase
    if (nxt_state == EXC_PEND && nxt_idx == head_idx) begin
      nxt_state = EXC_TRAP;
    end
    if (i_flush) begin
      nxt_state = EXC_IDLE;
      nxt_idx   = '0;
      nxt_cause = '0;
      nxt_tval  = '0;
      cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EXC_IDLE;
      held_idx   <= '0;
      held_cause <= '0;
      held_tval  <= '0;
      exc_vld_q  <= 1'b0;
      trap_req_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state      <= nxt_state;
      held_idx   <= nxt_idx;
      held_cause <= nxt_cause;
      held_tval  <= nxt_tval;
      exc_vld_q  <= (nxt_state != EXC_IDLE);
      trap_req_q <= (nxt_state == EXC_TRAP);
      if (cnt_inc && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_exc_vld    = exc_vld_q;
  assign o_exc_robIdx = held_idx;
  assign o_exc_cause  = held_cause;
  assign o_exc_tval   = held_tval;
  assign o_trap_req   = trap_req_q;
  assign o_trap_cnt   = cnt_q;

endmodule

// File: tb/tb_exception_tracker.sv
// Directed bench for exception_tracker; trap counter narrowed to 4 bits so saturation is reachable quickly.
module tb_exception_tracker;

  localparam int NR  = 4;
  localparam int RW  = 7;
  localparam int CW  = 16;
  localparam int TW  = 64;
  localparam int NW  = 4;

  logic                 clk;
  logic                 rst;
  logic [NR-1:0]        rep_vld;
  logic [NR*RW-1:0]     rep_rob;
  logic [NR*CW-1:0]     rep_cause;
  logic [NR*TW-1:0]     rep_tval;
  logic [RW-1:0]        head;
  logic                 squash_vld;
  logic [RW-1:0]        squash_rob;
  logic                 flush;
  logic                 trap_ack;
  logic                 exc_vld;
  logic [RW-1:0]        exc_rob;
  logic [CW-1:0]        exc_cause;
  logic [TW-1:0]        exc_tval;
  logic                 trap_req;
  logic [NW-1:0]        trap_cnt;

  int n_checks = 0;
  int n_errors = 0;

  exception_tracker #(.NUM_REPORT(NR), .ROB_SIZE(64), .CAUSE_W(CW), .TVAL_W(TW), .CNT_W(NW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_rep_vld       (rep_vld),
    .i_rep_robIdx    (rep_rob),
    .i_rep_cause     (rep_cause),
    .i_rep_tval      (rep_tval),
    .i_head_robIdx   (head),
    .i_squash_vld    (squash_vld),
    .i_squash_robIdx (squash_rob),
    .i_flush         (flush),
    .i_trap_ack      (trap_ack),
    .o_exc_vld       (exc_vld),
    .o_exc_robIdx    (exc_rob),
    .o_exc_cause     (exc_cause),
    .o_exc_tval      (exc_tval),
    .o_trap_req      (trap_req),
    .o_trap_cnt      (trap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] ri(input logic f, input int i);
    return {f, 6'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rep(input int ch, input logic [RW-1:0] r, input logic [CW-1:0] c,
                         input logic [TW-1:0] t);
    rep_vld[ch]            = 1'b1;
    rep_rob[ch*RW +: RW]   = r;
    rep_cause[ch*CW +: CW] = c;
    rep_tval[ch*TW +: TW]  = t;
  endtask

  task automatic clr_inputs();
    rep_vld    = '0;
    rep_rob    = '0;
    rep_cause  = '0;
    rep_tval   = '0;
    squash_vld = 1'b0;
    squash_rob = '0;
    flush      = 1'b0;
    trap_ack   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr_inputs();
    head = '0;
    tick();
    tick();
    rst = 1'b1;
    n_checks++;
    if (exc_vld !== 1'b0 || trap_req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags vld=%0b req=%0b expected 0 0", exc_vld, trap_req);
    end
    n_checks++;
    if (exc_rob !== '0 || exc_cause !== '0 || exc_tval !== '0) begin
      n_errors++;
      $display("FAIL reset_data rob=%h cause=%h tval=%h expected 0", exc_rob, exc_cause, exc_tval);
    end
    n_checks++;
    if (trap_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_cnt got %0d expected 0", trap_cnt);
    end
  endtask

  task automatic test_single();
    head = ri(0, 3);
    set_rep(2, ri(0, 5), 16'd5, 64'h1000);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_vld !== 1'b1 || exc_rob !== ri(0, 5) || exc_cause !== 16'd5 || exc_tval !== 64'h1000) begin
      n_errors++;
      $display("FAIL single_capture vld=%0b rob=%h cause=%h tval=%h expected 1 05 5 1000",
               exc_vld, exc_rob, exc_cause, exc_tval);
    end
    n_checks++;
    if (trap_req !== 1'b0) begin
      n_errors++;
      $display("FAIL single_no_req got %0b expected 0", trap_req);
    end
    head = ri(0, 5);
    tick();
    n_checks++;
    if (trap_req !== 1'b1) begin
      n_errors++;
      $display("FAIL single_head_req got %0b expected 1", trap_req);
    end
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    n_checks++;
    if (exc_vld !== 1'b0 || trap_req !== 1'b0 || trap_cnt !== 4'd1) begin
      n_errors++;
      $display("FAIL single_ack vld=%0b req=%0b cnt=%0d expected 0 0 1", exc_vld, trap_req, trap_cnt);
    end
  endtask

  task automatic test_same_cycle();
    head = ri(0, 40);
    set_rep(0, ri(0, 9), 16'd1, 64'h10);
    set_rep(1, ri(0, 7), 16'd2, 64'h11);
    set_rep(3, ri(0, 7), 16'd3, 64'h13);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_rob !== ri(0, 7) || exc_cause !== 16'd2 || exc_tval !== 64'h11) begin
      n_errors++;
      $display("FAIL tie_lowest_ch rob=%h cause=%h tval=%h expected 07 2 11", exc_rob, exc_cause, exc_tval);
    end
    set_rep(0, ri(0, 2), 16'd4, 64'h20);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_rob !== ri(0, 2) || exc_cause !== 16'd4) begin
      n_errors++;
      $display("FAIL older_replace rob=%h cause=%h expected 02 4", exc_rob, exc_cause);
    end
    set_rep(2, ri(0, 2), 16'd6, 64'h22);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_rob !== ri(0, 2) || exc_cause !== 16'd4 || exc_tval !== 64'h20) begin
      n_errors++;
      $display("FAIL same_idx_keep rob=%h cause=%h tval=%h expected 02 4 20", exc_rob, exc_cause, exc_tval);
    end
    do_flush();
    n_checks++;
    if (exc_vld !== 1'b0 || trap_req !== 1'b0 || exc_rob !== '0 || exc_cause !== '0 || trap_cnt !== 4'd1) begin
      n_errors++;
      $display("FAIL flush_pend vld=%0b req=%0b rob=%h cause=%h cnt=%0d expected 0 0 0 0 1",
               exc_vld, trap_req, exc_rob, exc_cause, trap_cnt);
    end
  endtask

  task automatic test_wrap();
    head = ri(0, 40);
    set_rep(0, ri(0, 62), 16'd7, 64'h62);
    tick();
    set_rep(0, ri(1, 1), 16'd8, 64'h81);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_rob !== ri(0, 62) || exc_cause !== 16'd7) begin
      n_errors++;
      $display("FAIL wrap_younger rob=%h cause=%h expected 3e 7", exc_rob, exc_cause);
    end
    do_flush();
    set_rep(0, ri(1, 1), 16'd8, 64'h81);
    tick();
    set_rep(0, ri(0, 62), 16'd7, 64'h62);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_rob !== ri(0, 62) || exc_cause !== 16'd7 || exc_tval !== 64'h62) begin
      n_errors++;
      $display("FAIL wrap_older rob=%h cause=%h tval=%h expected 3e 7 62", exc_rob, exc_cause, exc_tval);
    end
    do_flush();
  endtask

  task automatic test_squash();
    head = ri(0, 40);
    set_rep(0, ri(0, 20), 16'd1, 64'h1);
    tick();
    clr_inputs();
    squash_vld = 1'b1;
    squash_rob = ri(0, 10);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_vld !== 1'b0 || exc_rob !== '0) begin
      n_errors++;
      $display("FAIL squash_clear vld=%0b rob=%h expected 0 00", exc_vld, exc_rob);
    end
    set_rep(0, ri(0, 20), 16'd1, 64'h1);
    tick();
    clr_inputs();
    squash_vld = 1'b1;
    squash_rob = ri(0, 10);
    set_rep(0, ri(0, 9), 16'd3, 64'h3);
    set_rep(1, ri(0, 8), 16'd9, 64'h9);
    set_rep(2, ri(0, 12), 16'd2, 64'h2);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_vld !== 1'b1 || exc_rob !== ri(0, 8) || exc_cause !== 16'd9) begin
      n_errors++;
      $display("FAIL squash_recapture vld=%0b rob=%h cause=%h expected 1 08 9", exc_vld, exc_rob, exc_cause);
    end
    do_flush();
    set_rep(0, ri(0, 20), 16'd1, 64'h1);
    tick();
    clr_inputs();
    squash_vld = 1'b1;
    squash_rob = ri(0, 20);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_vld !== 1'b1 || exc_rob !== ri(0, 20)) begin
      n_errors++;
      $display("FAIL squash_self_kept vld=%0b rob=%h expected 1 14", exc_vld, exc_rob);
    end
    do_flush();
    squash_vld = 1'b1;
    squash_rob = ri(0, 10);
    set_rep(1, ri(0, 12), 16'd2, 64'h2);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL squash_filter vld=%0b expected 0", exc_vld);
    end
  endtask

  task automatic test_trap_ack();
    head = ri(0, 30);
    set_rep(0, ri(0, 30), 16'd5, 64'h30);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_vld !== 1'b1 || trap_req !== 1'b1) begin
      n_errors++;
      $display("FAIL head_capture_req vld=%0b req=%0b expected 1 1", exc_vld, trap_req);
    end
    set_rep(0, ri(0, 1), 16'd2, 64'h1);
    squash_vld = 1'b1;
    squash_rob = ri(0, 0);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_rob !== ri(0, 30) || exc_cause !== 16'd5 || trap_req !== 1'b1) begin
      n_errors++;
      $display("FAIL trap_ignores rob=%h cause=%h req=%0b expected 1e 5 1", exc_rob, exc_cause, trap_req);
    end
    trap_ack = 1'b1;
    set_rep(0, ri(0, 1), 16'd2, 64'h1);
    tick();
    clr_inputs();
    n_checks++;
    if (exc_vld !== 1'b0 || trap_req !== 1'b0 || trap_cnt !== 4'd2) begin
      n_errors++;
      $display("FAIL ack_drop vld=%0b req=%0b cnt=%0d expected 0 0 2", exc_vld, trap_req, trap_cnt);
    end
    tick();
    n_checks++;
    if (exc_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL ack_report_dropped vld=%0b expected 0", exc_vld);
    end
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    n_checks++;
    if (trap_cnt !== 4'd2) begin
      n_errors++;
      $display("FAIL ack_in_idle cnt=%0d expected 2", trap_cnt);
    end
  endtask

  task automatic test_flush_trap();
    head = ri(0, 30);
    set_rep(3, ri(0, 30), 16'd7, 64'h77);
    tick();
    clr_inputs();
    flush    = 1'b1;
    trap_ack = 1'b1;
    tick();
    clr_inputs();
    n_checks++;
    if (exc_vld !== 1'b0 || trap_req !== 1'b0 || exc_rob !== '0 || exc_cause !== '0 ||
        exc_tval !== '0 || trap_cnt !== 4'd2) begin
      n_errors++;
      $display("FAIL flush_trap vld=%0b req=%0b rob=%h cause=%h tval=%h cnt=%0d expected 0 0 0 0 0 2",
               exc_vld, trap_req, exc_rob, exc_cause, exc_tval, trap_cnt);
    end
  endtask

  task automatic test_saturate();
    head = ri(0, 30);
    for (int i = 0; i < 15; i++) begin
      set_rep(0, ri(0, 30), 16'd1, 64'h0);
      tick();
      clr_inputs();
      trap_ack = 1'b1;
      tick();
      trap_ack = 1'b0;
      if (i == 12) begin
        n_checks++;
        if (trap_cnt !== 4'hF) begin
          n_errors++;
          $display("FAIL cnt_reach_max cnt=%0d expected 15", trap_cnt);
        end
      end
    end
    n_checks++;
    if (trap_cnt !== 4'hF) begin
      n_errors++;
      $display("FAIL cnt_saturate cnt=%0d expected 15", trap_cnt);
    end
  endtask

  task automatic test_rst_trap();
    head = ri(0, 30);
    set_rep(1, ri(0, 30), 16'd4, 64'h44);
    tick();
    clr_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (exc_vld !== 1'b0 || trap_req !== 1'b0 || exc_rob !== '0 || exc_cause !== '0 ||
        exc_tval !== '0 || trap_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL rst_mid_trap vld=%0b req=%0b rob=%h cause=%h tval=%h cnt=%0d expected all 0",
               exc_vld, trap_req, exc_rob, exc_cause, exc_tval, trap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_wrap();
    test_squash();
    test_trap_ack();
    test_flush_trap();
    test_saturate();
    test_rst_trap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
